// File: rtl/gate_range_ctrl.sv
// Gate/range controller for a reciprocal-free frequency counter.
// Sequences clear -> gate -> latch -> decide -> hold, and picks the gate
// length for each measurement either from range_sel or by autoranging on
// the datapath overflow / low-count flags.
module gate_range_ctrl #(
  parameter int CLK_HZ   = 50000000,
  parameter int CLR_CYC  = 4,
  parameter int HOLD_CYC = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       auto_en,
  input  logic [1:0] range_sel,
  input  logic       cnt_ovf,
  input  logic       cnt_low,
  output logic       cnt_clean,
  output logic       cnt_en,
  output logic       lat_en,
  output logic [1:0] range,
  output logic       valid,
  output logic       over_range
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_GATE,
    S_LATCH,
    S_DECIDE,
    S_HOLD
  } state_t;

  // Gate lengths per range; a zero-length gate is stretched to one cycle.
  localparam int unsigned N0 = (CLK_HZ       > 0) ? CLK_HZ       : 1;
  localparam int unsigned N1 = (CLK_HZ / 10  > 0) ? CLK_HZ / 10  : 1;
  localparam int unsigned N2 = (CLK_HZ / 100 > 0) ? CLK_HZ / 100 : 1;
  localparam logic [31:0] G0_LAST   = 32'(N0 - 1);
  localparam logic [31:0] G1_LAST   = 32'(N1 - 1);
  localparam logic [31:0] G2_LAST   = 32'(N2 - 1);
  localparam logic [31:0] CLR_LAST  = (CLR_CYC  > 0) ? 32'(CLR_CYC - 1)  : 32'd0;
  localparam logic [31:0] HOLD_LAST = (HOLD_CYC > 0) ? 32'(HOLD_CYC - 1) : 32'd0;

  state_t      state, state_next;
  logic [31:0] ph_cnt;      // cycles spent in CLEAR / HOLD
  logic [31:0] gate_tmr;    // gate timer, loaded N-1, counts down to 0
  logic [1:0]  gate_range;  // range frozen for the current gate
  logic [1:0]  next_range;  // range decided at the last DECIDE
  logic [1:0]  range_q;
  logic        ovr_q;
  logic        load_pend;   // first CLEAR after reset still has to freeze a range

  logic [1:0]  sel_sat;
  logic [1:0]  auto_nxt;
  logic [1:0]  decide_nxt;
  logic [1:0]  entry_range;
  logic [31:0] entry_last;
  logic        ovr_now;
  logic        enter_clear;

  // Range arithmetic: saturating autorange step, manual select clamp, and the
  // range to freeze when the next CLEAR begins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    sel_sat    = (range_sel == 2'd3) ? 2'd2 : range_sel;
    auto_nxt   = gate_range;
    if (cnt_ovf) begin
      if (gate_range < 2'd2) auto_nxt = gate_range + 2'd1;
    end else if (cnt_low) begin
      if (gate_range > 2'd0) auto_nxt = gate_range - 2'd1;
    end
    decide_nxt = auto_en ? auto_nxt : sel_sat;
    // With HOLD skipped, DECIDE flows straight into CLEAR and the fresh
    // decision must be used before it reaches next_range.
    if (auto_en) entry_range = (state == S_DECIDE) ? auto_nxt : next_range;
    else         entry_range = sel_sat;
    case (entry_range)
      2'd0:    entry_last = G0_LAST;
      2'd1:    entry_last = G1_LAST;
      default: entry_last = G2_LAST;
    endcase
    ovr_now = cnt_ovf && (gate_range == 2'd2);
  end

  // Next-state logic and per-state output decode.
  always_comb begin
    state_next = state;
    cnt_clean  = 1'b1;
    cnt_en     = 1'b0;
    lat_en     = 1'b0;
    valid      = 1'b0;
    case (state)
      S_CLEAR: begin
        cnt_clean = 1'b0;
        if (ph_cnt >= CLR_LAST) state_next = S_GATE;
      end
      S_GATE: begin
        cnt_en = 1'b1;
        if (gate_tmr == 32'd0) state_next = S_LATCH;
      end
      S_LATCH: begin
        lat_en     = 1'b1;
        state_next = S_DECIDE;
      end
      S_DECIDE: begin
        valid      = 1'b1;
        state_next = (HOLD_CYC == 0) ? S_CLEAR : S_HOLD;
      end
      S_HOLD: begin
        if (ph_cnt >= HOLD_LAST) state_next = S_CLEAR;
      end
      default: state_next = S_CLEAR;
    endcase
    enter_clear = (state_next == S_CLEAR) && (state != S_CLEAR);
  end

  assign range      = range_q;
  assign over_range = (state == S_DECIDE) ? ovr_now : ovr_q;

  // State, phase counter, gate timer and latched result registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state      <= S_CLEAR;
      ph_cnt     <= 32'd0;
      gate_tmr   <= G0_LAST;
      gate_range <= 2'd0;
      next_range <= 2'd0;
      range_q    <= 2'd0;
      ovr_q      <= 1'b0;
      load_pend  <= 1'b1;
    end else begin
      state     <= state_next;
      ph_cnt    <= (state_next != state) ? 32'd0 : ph_cnt + 32'd1;
      load_pend <= 1'b0;
      if (enter_clear || load_pend) begin
        gate_range <= entry_range;
        gate_tmr   <= entry_last;
      end else if (state == S_GATE && gate_tmr != 32'd0) begin
        gate_tmr <= gate_tmr - 32'd1;
      end
      if (state == S_LATCH) range_q <= gate_range;
      if (state == S_DECIDE) begin
        ovr_q      <= ovr_now;
        next_range <= decide_nxt;
      end
    end
  end

endmodule

// File: tb/tb_gate_range_ctrl.sv
// Directed bench for gate_range_ctrl with CLK_HZ=1000, CLR_CYC=2, HOLD_CYC=3.
module tb_gate_range_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       auto_en;
  logic [1:0] range_sel;
  logic       cnt_ovf;
  logic       cnt_low;
  logic       cnt_clean;
  logic       cnt_en;
  logic       lat_en;
  logic [1:0] range;
  logic       valid;
  logic       over_range;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int viol     = 0;

  localparam int BOUND = 3000;

  gate_range_ctrl #(.CLK_HZ(1000), .CLR_CYC(2), .HOLD_CYC(3)) dut (
    .clk(clk), .reset(reset), .auto_en(auto_en), .range_sel(range_sel),
    .cnt_ovf(cnt_ovf), .cnt_low(cnt_low), .cnt_clean(cnt_clean),
    .cnt_en(cnt_en), .lat_en(lat_en), .range(range), .valid(valid),
    .over_range(over_range)
  );

  always #5 clk = ~clk;

  // Output invariants sampled every cycle outside reset.
  always @(negedge clk) begin
    if (reset === 1'b1 && ((cnt_en && lat_en) || (cnt_en && !cnt_clean))) viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Counts the cycles a level holds at negedges; an expired bound is reported
  // through the length comparison that follows.
  task automatic count_while(input int which, output int n);
    n = 0;
    while (n < BOUND &&
           ((which == 0 && cnt_clean === 1'b0) ||
            (which == 1 && cnt_en === 1'b1) ||
            (which == 2 && cnt_clean === 1'b1))) begin
      n++;
      @(negedge clk);
    end
  endtask

  // One full measurement starting at a negedge inside CLEAR; optional
  // range_sel change at gate cycle chg_at.
  task automatic run_cycle(input string tag, input int exp_gate, input logic [1:0] exp_rng,
                           input logic exp_ovr, input int chg_at, input logic [1:0] chg_val);
    int n;
    n = 0;
    count_while(0, n);
    check({tag, " clear_len"}, n, 2);
    n = 0;
    while (n < BOUND && cnt_en === 1'b1) begin
      n++;
      if (n == chg_at) range_sel = chg_val;
      @(negedge clk);
    end
    check({tag, " gate_len"}, n, exp_gate);
    check({tag, " lat_en"}, lat_en, 1);
    check({tag, " lat_no_valid"}, valid, 0);
    @(negedge clk);
    check({tag, " valid"}, valid, 1);
    check({tag, " range"}, range, exp_rng);
    check({tag, " over_range"}, over_range, exp_ovr);
    @(negedge clk);
    count_while(2, n);
    check({tag, " hold_len"}, n, 3);
  endtask

  initial begin
    int n;
    reset = 1'b0; auto_en = 1'b1; range_sel = 2'd0; cnt_ovf = 1'b0; cnt_low = 1'b0;
    #1;
    check("rst cnt_clean", cnt_clean, 0);
    check("rst cnt_en", cnt_en, 0);
    check("rst lat_en", lat_en, 0);
    check("rst valid", valid, 0);
    check("rst range", range, 0);
    check("rst over_range", over_range, 0);
    @(negedge clk);
    reset = 1'b1;

    // Basic auto mode, no flags.
    run_cycle("base1", 1000, 0, 0, -1, 0);
    run_cycle("base2", 1000, 0, 0, -1, 0);

    // Autorange up, saturating at range 2.
    cnt_ovf = 1'b1;
    run_cycle("up1", 1000, 0, 0, -1, 0);
    run_cycle("up2", 100, 1, 0, -1, 0);
    run_cycle("up3", 10, 2, 1, -1, 0);
    run_cycle("up4", 10, 2, 1, -1, 0);

    // Autorange down, saturating at range 0.
    cnt_ovf = 1'b0; cnt_low = 1'b1;
    run_cycle("dn1", 10, 2, 0, -1, 0);
    run_cycle("dn2", 100, 1, 0, -1, 0);
    run_cycle("dn3", 1000, 0, 0, -1, 0);
    cnt_ovf = 1'b1; cnt_low = 1'b0;
    run_cycle("dn4", 1000, 0, 0, -1, 0);
    cnt_low = 1'b1;
    run_cycle("both", 100, 1, 0, -1, 0);
    cnt_ovf = 1'b0; cnt_low = 1'b0;
    run_cycle("both_next", 10, 2, 0, -1, 0);

    // Manual mode; the current CLEAR already froze auto's range 2.
    auto_en = 1'b0; range_sel = 2'd3;
    run_cycle("man1", 10, 2, 0, -1, 0);
    cnt_ovf = 1'b1;
    run_cycle("man_chg", 10, 2, 1, 5, 2'd0);
    range_sel = 2'd2;
    run_cycle("man_after", 1000, 0, 0, -1, 0);
    range_sel = 2'd0;
    run_cycle("man_r2", 10, 2, 1, -1, 0);

    // Reset in the middle of a 1000-cycle gate.
    cnt_ovf = 1'b0;
    count_while(0, n);
    check("mid clear_len", n, 2);
    n = 0;
    while (n < 500 && cnt_en === 1'b1) begin
      n++;
      @(negedge clk);
    end
    check("mid gate_reached", n, 500);
    check("mid pre range", range, 2);
    check("mid pre over_range", over_range, 1);
    reset = 1'b0;
    #1;
    check("mid cnt_clean", cnt_clean, 0);
    check("mid cnt_en", cnt_en, 0);
    check("mid range", range, 0);
    check("mid over_range", over_range, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid no lat_en", lat_en, 0);
      check("mid no valid", valid, 0);
    end
    auto_en = 1'b0; range_sel = 2'd1;
    reset = 1'b1;
    run_cycle("restart", 100, 1, 0, -1, 0);

    check("invariants", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gate_range_ctrl.md
GATE_RANGE_CTRL -- requirements
Module: gate_range_ctrl

Interface
REQ-001 Parameter CLK_HZ, 50000000, system clock frequency in Hz; 1 s gate length in cycles.
REQ-002 Parameter CLR_CYC, 4, cycles cnt_clean is held low before each gate.
REQ-003 Parameter HOLD_CYC, 25000000, cycles the latched result is held between measurements.
REQ-004 clk  in  1  system clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 auto_en  in  1  1 = autorange, 0 = manual range from range_sel.
REQ-007 range_sel  in  2  manual range: 0 = 1 s, 1 = 100 ms, 2 = 10 ms gate; 3 treated as 2.
REQ-008 cnt_ovf  in  1  datapath counter overflowed this gate; level, held until cleared.
REQ-009 cnt_low  in  1  datapath count below 10% full scale (top digit zero); level.
REQ-010 cnt_clean  out  1  active-low counter clear to datapath.
REQ-011 cnt_en  out  1  counter enable (gate open).
REQ-012 lat_en  out  1  one-cycle latch strobe to result register.
REQ-013 range  out  2  gate range in effect for the latched result.
REQ-014 valid  out  1  one-cycle pulse, new result latched.
REQ-015 over_range  out  1  latched result overflowed on the shortest gate.

Function
REQ-016 FSM states: CLEAR, GATE, LATCH, DECIDE, HOLD; cyclic in that order, HOLD -> CLEAR.
REQ-017 CLEAR: cnt_clean=0, cnt_en=0; exactly CLR_CYC cycles; gate length and next range frozen on CLEAR entry.
REQ-018 GATE: cnt_clean=1, cnt_en=1 for exactly N cycles; N = CLK_HZ, CLK_HZ/10, CLK_HZ/100 for range 0/1/2 (integer division).
REQ-019 Gate timer 32 bits, loaded N-1, decrements to 0; no gate shorter than 1 cycle (N=0 forced to 1).
REQ-020 LATCH: single cycle, cnt_en=0, lat_en=1, cnt_clean=1.
REQ-021 DECIDE: single cycle; samples cnt_ovf, cnt_low; valid=1 and range/over_range updated this cycle.
REQ-022 range output reports the range used for the gate just latched.
REQ-023 Autorange next range: cnt_ovf and range<2 -> range+1; cnt_low and range>0 -> range-1; else unchanged.
REQ-024 cnt_ovf and cnt_low both 1: cnt_ovf wins.
REQ-025 over_range = cnt_ovf and gate range was 2; held until next DECIDE.
REQ-026 cnt_ovf at range 2 or cnt_low at range 0: range unchanged, no wrap.
REQ-027 Manual mode: next range = range_sel (3 -> 2); cnt_ovf/cnt_low ignored for range, over_range still computed.
REQ-028 auto_en or range_sel changing mid-cycle: takes effect at next CLEAR entry only; current gate length never altered.
REQ-029 HOLD: cnt_en=0, cnt_clean=1, for HOLD_CYC cycles (HOLD_CYC=0 -> HOLD skipped).
REQ-030 cnt_en and lat_en never high in the same cycle; cnt_en never high while cnt_clean=0.

Reset
REQ-031 reset low: state CLEAR, timer reloaded, cnt_clean=0, cnt_en=0, lat_en=0, valid=0, over_range=0, range=0, next range=0, immediately without clock.
REQ-032 Reset mid-GATE or mid-LATCH: gate aborted, no lat_en or valid issued for it.
REQ-033 After reset release: first CLEAR lasts full CLR_CYC cycles, then a range-0 gate (manual: range_sel).

Verification (CLK_HZ=1000, CLR_CYC=2, HOLD_CYC=3)
REQ-034 Release reset, auto_en=1, inputs 0 -> cnt_clean low 2 cycles, cnt_en high 1000 cycles, lat_en 1 cycle, valid next cycle with range=0, 3 hold cycles, repeat.
REQ-035 Autorange up: cnt_ovf=1 each gate -> gates 1000, 100, 10, 10 cycles; over_range=1 on third and later results, range stays 2.
REQ-036 Autorange down from range 2: cnt_low=1 -> gates 10, 100, 1000, 1000; both cnt_ovf and cnt_low at range 1 -> next gate 10.
REQ-037 Manual: auto_en=0, range_sel=3 -> 10-cycle gates; change range_sel to 0 mid-gate -> current gate stays 10, next 1000.
REQ-038 Reset asserted at gate cycle 500 -> all outputs to reset values same cycle, no lat_en/valid; restart per REQ-033.
